// File: rtl/alu_response_checker.sv
// alu_response_checker
//   On-chip response checker for ALU self-test. Each issued ALU operation
//   comes with an expected-response packet. The packet travels down a
//   LATENCY-deep delay line and is compared bit-exactly with the live ALU
//   outputs when it reaches the last stage. The result {feature_id, pass}
//   is written to a result memory, and a pass or fail counter is bumped.
//
//   Ports
//     CLK, RST          clock, asynchronous active-high reset
//     START             pulse: clear counters and pointers, enter RUN
//     ISSUE_VALID       an ALU operation was applied this cycle
//     FEATURE_ID        feature ID of the issued case
//     EXP_*             expected RES/COUT/EGL/OFLOW/ERR of the issued case
//     RES..ERR          live ALU outputs
//     RD_ADDR/RD_DATA   result memory read port, RD_DATA = {id, pass}, 1-cycle latency
//     PASS_CNT/FAIL_CNT saturating case counters
//     BUSY / DONE       high in RUN / DONE
//
//   Optional build macro ALU_CHK_FIRST_FAIL_EN adds FIRST_FAIL_VALID,
//   FIRST_FAIL_ID and FIRST_FAIL_OBS. These capture the first failing case
//   seen since START or reset.
module alu_response_checker #(
    parameter int RES_W   = 9,
    parameter int LATENCY = 3,
    parameter int NUM_TC  = 130,
    parameter int PTR_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ISSUE_VALID,
    input  logic [7:0]       FEATURE_ID,
    input  logic [RES_W-1:0] EXP_RES,
    input  logic             EXP_COUT,
    input  logic [2:0]       EXP_EGL,
    input  logic             EXP_OFLOW,
    input  logic             EXP_ERR,
    input  logic [RES_W-1:0] RES,
    input  logic             COUT,
    input  logic [2:0]       EGL,
    input  logic             OFLOW,
    input  logic             ERR,
    input  logic [PTR_W-1:0] RD_ADDR,
    output logic [8:0]       RD_DATA,
    output logic [PTR_W-1:0] PASS_CNT,
    output logic [PTR_W-1:0] FAIL_CNT,
    output logic             BUSY,
    output logic             DONE
`ifdef ALU_CHK_FIRST_FAIL_EN
    ,
    output logic             FIRST_FAIL_VALID,
    output logic [7:0]       FIRST_FAIL_ID,
    output logic [RES_W+5:0] FIRST_FAIL_OBS
`endif
);

    localparam int OBS_W = RES_W + 6;
    localparam int CNT_W = $clog2(NUM_TC + 1);
    localparam int DEPTH = 2 ** PTR_W;
    localparam logic [PTR_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                        state_q, state_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [LATENCY-1:0][7:0]       id_q, id_d;
    logic [LATENCY-1:0][OBS_W-1:0] exp_q, exp_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              pass_cnt_q, pass_cnt_d;
    logic [PTR_W-1:0]              fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]              log_cnt_q, log_cnt_d;
    logic [8:0]                    rd_data_q, rd_data_d;
    logic [8:0]                    mem [DEPTH];

    logic [OBS_W-1:0] obs_word;
    logic             accept;
    logic             keep;
    logic             log_en;
    logic             pass;

    always_comb begin
        obs_word = {RES, COUT, EGL, OFLOW, ERR};
        // A START-cycle issue becomes the first case of the new run.
        accept   = ISSUE_VALID && (START || state_q == S_RUN);
        // In-flight packets survive only while RUN continues without a restart.
        keep     = (state_q == S_RUN) && !START;
        log_en   = keep && vld_q[LATENCY-1];
        pass     = (obs_word == exp_q[LATENCY-1]);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        log_cnt_d  = log_cnt_q;
        rd_data_d  = mem[RD_ADDR];

        vld_d    = vld_q;
        id_d     = id_q;
        exp_d    = exp_q;
        vld_d[0] = accept;
        id_d[0]  = FEATURE_ID;
        exp_d[0] = {EXP_RES, EXP_COUT, EXP_EGL, EXP_OFLOW, EXP_ERR};
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = keep && vld_q[i-1];
            id_d[i]  = id_q[i-1];
            exp_d[i] = exp_q[i-1];
        end

        if (log_en) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            log_cnt_d = log_cnt_q + CNT_W'(1);
            if (pass) begin
                if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + PTR_W'(1);
            end else begin
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + PTR_W'(1);
            end
            if (log_cnt_d == CNT_W'(NUM_TC)) state_d = S_DONE;
        end

        if (START) begin
            state_d    = S_RUN;
            wr_ptr_d   = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            log_cnt_d  = '0;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_q      <= '0;
            id_q       <= '0;
            exp_q      <= '0;
            wr_ptr_q   <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            log_cnt_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
            exp_q      <= exp_d;
            wr_ptr_q   <= wr_ptr_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            log_cnt_q  <= log_cnt_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Result memory is not reset. A read and a write to the same address in
    // one cycle return the old word.
    always_ff @(posedge CLK) begin
        if (log_en) mem[wr_ptr_q] <= {id_q[LATENCY-1], pass};
    end

    assign RD_DATA  = rd_data_q;
    assign PASS_CNT = pass_cnt_q;
    assign FAIL_CNT = fail_cnt_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

`ifdef ALU_CHK_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [7:0]       ff_id_q, ff_id_d;
    logic [OBS_W-1:0] ff_obs_q, ff_obs_d;

    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_id_d    = ff_id_q;
        ff_obs_d   = ff_obs_q;
        if (START) begin
            ff_valid_d = 1'b0;
            ff_id_d    = '0;
            ff_obs_d   = '0;
        end else if (log_en && !pass && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_id_d    = id_q[LATENCY-1];
            ff_obs_d   = obs_word;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ff_valid_q <= 1'b0;
            ff_id_q    <= '0;
            ff_obs_q   <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_id_q    <= ff_id_d;
            ff_obs_q   <= ff_obs_d;
        end
    end

    assign FIRST_FAIL_VALID = ff_valid_q;
    assign FIRST_FAIL_ID    = ff_id_q;
    assign FIRST_FAIL_OBS   = ff_obs_q;
`endif

endmodule

// File: tb/tb_alu_response_checker.sv
// Scoreboard bench for alu_response_checker.
// The main instance uses the default parameters. Two extra instances share
// the same inputs: one with NUM_TC=4 for DONE timing, and one with PTR_W=2
// and NUM_TC=6 for counter saturation.
module tb_alu_response_checker;
    localparam int RES_W  = 9;
    localparam int LAT    = 3;
    localparam int OBS_W  = RES_W + 6;
    localparam int NUM_TC = 130;

    logic CLK = 1'b0;
    logic RST, START, ISSUE_VALID;
    logic [7:0] FEATURE_ID, rd_addr;
    logic [OBS_W-1:0] exp_w, obs_w;

    logic [RES_W-1:0] exp_res, res;
    logic exp_cout, exp_oflow, exp_err, cout, oflow, err;
    logic [2:0] exp_egl, egl;
    assign {exp_res, exp_cout, exp_egl, exp_oflow, exp_err} = exp_w;
    assign {res, cout, egl, oflow, err} = obs_w;

    logic [8:0] rd_data, rd_data2, rd_data3;
    logic [7:0] pass_cnt, fail_cnt, pass_cnt2, fail_cnt2;
    logic [1:0] pass_cnt3, fail_cnt3;
    logic busy, done, busy2, done2, busy3, done3;
`ifdef ALU_CHK_FIRST_FAIL_EN
    logic ff_v, ff_v2, ff_v3;
    logic [7:0] ff_id, ff_id2, ff_id3;
    logic [OBS_W-1:0] ff_obs, ff_obs2, ff_obs3;
`endif

    always #5 CLK = ~CLK;

    alu_response_checker #(.RES_W(RES_W), .LATENCY(LAT), .NUM_TC(NUM_TC), .PTR_W(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ISSUE_VALID(ISSUE_VALID), .FEATURE_ID(FEATURE_ID),
        .EXP_RES(exp_res), .EXP_COUT(exp_cout), .EXP_EGL(exp_egl), .EXP_OFLOW(exp_oflow), .EXP_ERR(exp_err),
        .RES(res), .COUT(cout), .EGL(egl), .OFLOW(oflow), .ERR(err),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data), .PASS_CNT(pass_cnt), .FAIL_CNT(fail_cnt),
        .BUSY(busy), .DONE(done)
`ifdef ALU_CHK_FIRST_FAIL_EN
        , .FIRST_FAIL_VALID(ff_v), .FIRST_FAIL_ID(ff_id), .FIRST_FAIL_OBS(ff_obs)
`endif
    );

    alu_response_checker #(.RES_W(RES_W), .LATENCY(LAT), .NUM_TC(4), .PTR_W(8)) dut2 (
        .CLK(CLK), .RST(RST), .START(START), .ISSUE_VALID(ISSUE_VALID), .FEATURE_ID(FEATURE_ID),
        .EXP_RES(exp_res), .EXP_COUT(exp_cout), .EXP_EGL(exp_egl), .EXP_OFLOW(exp_oflow), .EXP_ERR(exp_err),
        .RES(res), .COUT(cout), .EGL(egl), .OFLOW(oflow), .ERR(err),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data2), .PASS_CNT(pass_cnt2), .FAIL_CNT(fail_cnt2),
        .BUSY(busy2), .DONE(done2)
`ifdef ALU_CHK_FIRST_FAIL_EN
        , .FIRST_FAIL_VALID(ff_v2), .FIRST_FAIL_ID(ff_id2), .FIRST_FAIL_OBS(ff_obs2)
`endif
    );

    alu_response_checker #(.RES_W(RES_W), .LATENCY(LAT), .NUM_TC(6), .PTR_W(2)) dut3 (
        .CLK(CLK), .RST(RST), .START(START), .ISSUE_VALID(ISSUE_VALID), .FEATURE_ID(FEATURE_ID),
        .EXP_RES(exp_res), .EXP_COUT(exp_cout), .EXP_EGL(exp_egl), .EXP_OFLOW(exp_oflow), .EXP_ERR(exp_err),
        .RES(res), .COUT(cout), .EGL(egl), .OFLOW(oflow), .ERR(err),
        .RD_ADDR(rd_addr[1:0]), .RD_DATA(rd_data3), .PASS_CNT(pass_cnt3), .FAIL_CNT(fail_cnt3),
        .BUSY(busy3), .DONE(done3)
`ifdef ALU_CHK_FIRST_FAIL_EN
        , .FIRST_FAIL_VALID(ff_v3), .FIRST_FAIL_ID(ff_id3), .FIRST_FAIL_OBS(ff_obs3)
`endif
    );

    // ---------------- reference model state ----------------
    int checks = 0;
    int errors = 0;
    int slot = 0;
    int k = 0;
    bit started = 0;
    logic [8:0] sb_q [$];                 // expected {id, pass} in log order
    logic [8:0] exp_mem [256];
    logic [OBS_W-1:0] obs_sched [int];    // ALU word to present at a given slot
    bit m_ff_v = 0;
    logic [7:0] m_ff_id = '0;
    logic [OBS_W-1:0] m_ff_obs = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // One drive slot. Inputs change on the negedge, and the following posedge
    // samples them.
    task automatic step(input logic st, input logic iv, input logic [7:0] id, input logic [OBS_W-1:0] ew);
        @(negedge CLK);
        slot++;
        START = st; ISSUE_VALID = iv; FEATURE_ID = id; exp_w = ew;
        if (obs_sched.exists(slot)) begin
            obs_w = obs_sched[slot];
            obs_sched.delete(slot);
        end else begin
            obs_w = OBS_W'($urandom);
        end
        if (st) begin
            sb_q.delete(); k = 0; started = 1; m_ff_v = 0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'($urandom), OBS_W'($urandom));
    endtask

    // Issue one case. The ALU answer ow appears LAT slots later. A case is
    // logged only if fewer than NUM_TC cases were issued before it since START.
    task automatic issue(input logic st, input logic [7:0] id, input logic [OBS_W-1:0] ew, input logic [OBS_W-1:0] ow);
        step(st, 1'b1, id, ew);
        obs_sched[slot + LAT] = ow;
        if (started) begin
            if (k < NUM_TC) begin
                sb_q.push_back({id, ow == ew});
                exp_mem[k] = {id, ow == ew};
                if (ow != ew && !m_ff_v) begin
                    m_ff_v = 1; m_ff_id = id; m_ff_obs = ow;
                end
            end
            k++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_mem(input int n);
        for (int a = 0; a < n; a++) begin
            rd_addr = 8'(a);
            idle();
            chk($sformatf("mem[%0d]", a), 32'(rd_data), 32'(exp_mem[a]));
        end
    endtask

    // ---------------- monitor: pops on every counter step ----------------
    int pp = 0, pf = 0, pc, fc;
    logic [8:0] mon_e;
    always @(posedge CLK) begin
        #1;
        pc = int'(pass_cnt);
        fc = int'(fail_cnt);
        if (RST || (pc == 0 && fc == 0)) begin
            pp = 0; pf = 0;
        end else if ((pc == pp + 1 && fc == pf) || (fc == pf + 1 && pc == pp)) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_log: pass_cnt %0d fail_cnt %0d with nothing expected", pc, fc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("log_pass_bit", 32'(pc == pp + 1), 32'(mon_e[0]));
            end
            pp = pc; pf = fc;
        end else if (pc != pp || fc != pf) begin
            checks++; errors++;
            $display("FAIL cnt_step: got %0d/%0d after %0d/%0d", pc, fc, pp, pf);
            pp = pc; pf = fc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [OBS_W-1:0] w8, w9, wa, wb, wc, w;
    int s4;
    initial begin
        RST = 1; START = 0; ISSUE_VALID = 0; FEATURE_ID = 0;
        exp_w = '0; obs_w = '0; rd_addr = '0;
        repeat (3) @(negedge CLK);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        chk("rst_fail_cnt", 32'(fail_cnt), 0);
        chk("rst_busy_done", 32'({busy, done}), 0);
`ifdef ALU_CHK_FIRST_FAIL_EN
        chk("rst_ff", 32'({ff_v, ff_id, ff_obs}), 0);
`endif
        RST = 0;

        // In IDLE, issues are ignored.
        w = OBS_W'($urandom);
        issue(1'b0, 8'h77, w, w);
        repeat (6) idle();
        chk("idle_ignore", 32'(pass_cnt) + 32'(fail_cnt), 0);
        chk("idle_busy", 32'(busy), 0);

        // Single passing ADD 5+3.
        w8 = {9'h008, 6'b0};
        w9 = {9'h009, 6'b0};
        step(1'b1, 1'b0, 8'h00, '0);
        issue(1'b0, 8'h01, w8, w8);
        drain();
        chk("tc1_pass_cnt", 32'(pass_cnt), 1);
        chk("tc1_fail_cnt", 32'(fail_cnt), 0);
        chk("tc1_busy", 32'(busy), 1);
        check_mem(1);
        chk("tc1_mem0", 32'(rd_data), 32'({8'h01, 1'b1}));
`ifdef ALU_CHK_FIRST_FAIL_EN
        chk("tc1_ff_valid", 32'(ff_v), 0);
`endif

        // Same case failing, issued in the START cycle.
        issue(1'b1, 8'h01, w8, w9);
        drain();
        chk("tc2_fail_cnt", 32'(fail_cnt), 1);
        chk("tc2_pass_cnt", 32'(pass_cnt), 0);
        check_mem(1);
        chk("tc2_mem0", 32'(rd_data), 32'({8'h01, 1'b0}));
`ifdef ALU_CHK_FIRST_FAIL_EN
        chk("tc2_ff_valid", 32'(ff_v), 1);
        chk("tc2_ff_id", 32'(ff_id), 32'h01);
        chk("tc2_ff_obs_res", 32'(ff_obs[RES_W+5:6]), 32'h009);
`endif

        // Back-to-back: pass, pass, EGL-only mismatch.
        wa = OBS_W'($urandom); wb = OBS_W'($urandom); wc = OBS_W'($urandom);
        step(1'b1, 1'b0, 8'h00, '0);
        issue(1'b0, 8'h10, wa, wa);
        issue(1'b0, 8'h11, wb, wb);
        issue(1'b0, 8'h12, wc, wc ^ OBS_W'(15'h0008));
        drain();
        chk("b2b_pass_cnt", 32'(pass_cnt), 2);
        chk("b2b_fail_cnt", 32'(fail_cnt), 1);
        check_mem(3);

        // DONE timing on the NUM_TC=4 instance.
        step(1'b1, 1'b0, 8'h00, '0);
        s4 = 0;
        for (int i = 0; i < 6; i++) begin
            w = OBS_W'($urandom);
            issue(1'b0, 8'(8'h20 + i), w, w);
            if (i == 3) s4 = slot;
        end
        for (int j = 0; j < 6; j++) begin
            idle();
            chk($sformatf("done2_t%0d", j), 32'(done2), 32'(slot - 1 >= s4 + LAT));
            chk($sformatf("busy2_t%0d", j), 32'(busy2), 32'(slot - 1 < s4 + LAT));
        end
        chk("done2_total", 32'(pass_cnt2) + 32'(fail_cnt2), 4);
        for (int i = 0; i < 2; i++) begin
            w = OBS_W'($urandom);
            issue(1'b0, 8'(8'h30 + i), w, w);
        end
        drain();
        chk("done2_ignores", 32'(pass_cnt2), 4);
        chk("done2_hold", 32'(done2), 1);

        // Fail counter saturation on the PTR_W=2 instance.
        step(1'b1, 1'b0, 8'h00, '0);
        for (int i = 0; i < 8; i++) begin
            w = OBS_W'($urandom);
            issue(1'b0, 8'(8'h40 + i), w, w ^ OBS_W'(1));
        end
        drain();
        chk("sat_fail_cnt3", 32'(fail_cnt3), 3);
        chk("sat_pass_cnt3", 32'(pass_cnt3), 0);
        chk("sat_done3", 32'({busy3, done3}), 1);

        // Reset two cycles after an issue drops the in-flight case.
        step(1'b1, 1'b0, 8'h00, '0);
        w = OBS_W'($urandom);
        issue(1'b0, 8'h44, w, w);
        idle(); idle();
        RST = 1;
        sb_q.delete(); started = 0; m_ff_v = 0;
        idle(); idle();
        RST = 0;
        repeat (5) idle();
        chk("rstmid_cnts", 32'(pass_cnt) + 32'(fail_cnt), 0);
        chk("rstmid_idle", 32'({busy, done}), 0);
`ifdef ALU_CHK_FIRST_FAIL_EN
        chk("rstmid_ff", 32'(ff_v), 0);
`endif
        w = OBS_W'($urandom);
        issue(1'b1, 8'h5A, w, w);
        drain();
        chk("rstmid_relog", 32'(pass_cnt), 1);
        check_mem(1);

        // Randomized run long enough to reach DONE on the main instance.
        step(1'b1, 1'b0, 8'h00, '0);
        for (int i = 0; i < 260; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                w = OBS_W'($urandom);
                if ($urandom_range(0, 1) == 1)
                    issue(1'b0, 8'($urandom), w, w ^ (OBS_W'(1) << $urandom_range(0, OBS_W - 1)));
                else
                    issue(1'b0, 8'($urandom), w, w);
            end else begin
                idle();
            end
        end
        drain();
        chk("rnd_total", 32'(pass_cnt) + 32'(fail_cnt), 32'(k < NUM_TC ? k : NUM_TC));
        chk("rnd_done", 32'(done), 32'(k >= NUM_TC));
        chk("rnd_busy", 32'(busy), 32'(k < NUM_TC));
`ifdef ALU_CHK_FIRST_FAIL_EN
        chk("rnd_ff_valid", 32'(ff_v), 32'(m_ff_v));
        if (m_ff_v) begin
            chk("rnd_ff_id", 32'(ff_id), 32'(m_ff_id));
            chk("rnd_ff_obs", 32'(ff_obs), 32'(m_ff_obs));
        end
`endif
        check_mem(k < NUM_TC ? k : NUM_TC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_response_checker.md
Name: alu_response_checker

Overview:
- Synthesizable, on-chip response checker for the ALU; the receiving end of the stimulus/response flow that the ALU self-test bench drives.
- Accepts one expected-response packet per issued ALU operation and samples the ALU outputs a fixed number of cycles later.
- Compares them bit-exactly and logs PASS/FAIL per feature ID into a result memory with pass/fail counters.
- Sits beside the ALU in BIST/bring-up builds; result memory is read back through a simple address/data port.

Parameters:
- RES_W, 9, ALU result width (width_OP+1; 16 for multiply builds).
- LATENCY, 3, cycles from issue to ALU output valid (4 for multiply builds); legal range 1..8.
- NUM_TC, 130, number of test cases logged before DONE.
- PTR_W, 8, result memory address width; 2**PTR_W >= NUM_TC.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  pulse; clears counters and pointers and enters RUN.
- ISSUE_VALID  in  1  an ALU operation was applied this cycle.
- FEATURE_ID  in  8  feature ID of the issued case.
- EXP_RES  in  RES_W  expected RES.
- EXP_COUT  in  1  expected COUT.
- EXP_EGL  in  3  expected {E,G,L}.
- EXP_OFLOW  in  1  expected OFLOW.
- EXP_ERR  in  1  expected ERR.
- RES  in  RES_W  ALU RES.
- COUT  in  1  ALU COUT.
- EGL  in  3  ALU {E,G,L}.
- OFLOW  in  1  ALU OFLOW.
- ERR  in  1  ALU ERR.
- RD_ADDR  in  PTR_W  result memory read address.
- RD_DATA  out  9  {feature_id[7:0], pass}; registered, 1-cycle read latency.
- PASS_CNT  out  PTR_W  number of passing cases.
- FAIL_CNT  out  PTR_W  number of failing cases.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in DONE.

Behaviour:
- Reset values:
  - RD_DATA, PASS_CNT, FAIL_CNT, BUSY, DONE are 0.
  - The delay-line valid bits are 0; the write pointer is 0.
  - Result memory contents are not reset.
- FSM states:
  - IDLE: entered on reset. START -> RUN. ISSUE_VALID is ignored.
  - RUN: BUSY=1. The logged-case count reaching NUM_TC -> DONE.
  - DONE: DONE=1. START -> RUN. Further ISSUE_VALID is ignored.
- START in any state:
  - Clears the counters, the write pointer and all delay-line valid bits on the same edge.
  - An ISSUE_VALID in the START cycle is accepted as the first case.
- Delay line:
  - ISSUE_VALID in RUN loads {valid, FEATURE_ID, expected fields} into a LATENCY-deep shift register.
  - Back-to-back issue is supported, one case per cycle; a packet reaches the output stage exactly LATENCY cycles after issue.
- Compare at the output stage:
  - The observed word {RES,COUT,EGL,OFLOW,ERR} is compared against the expected word with full equality.
  - Pass = all bits equal.
- Logging, on the same edge:
  - Write {feature_id, pass} at the write pointer; increment the write pointer.
  - Increment PASS_CNT or FAIL_CNT.
- Boundary conditions:
  - The NUM_TC-th write moves the FSM to DONE on that edge.
  - Packets still in flight are discarded.
  - No write ever occurs at address >= NUM_TC.
- Read port:
  - RD_DATA <= mem[RD_ADDR] every cycle.
  - Reads of unwritten addresses return undefined data.
  - A read and a write to the same address in the same cycle returns the old data.
- Counters saturate at 2**PTR_W-1; they never wrap.
- Reset mid-RUN returns the block to IDLE immediately and clears all in-flight packets.

Optional Feature:
- Macro: ALU_CHK_FIRST_FAIL_EN.
- When defined, add outputs:
  - FIRST_FAIL_VALID (1).
  - FIRST_FAIL_ID (8).
  - FIRST_FAIL_OBS (RES_W+6), the observed word.
- These capture the first failing case after START/reset and hold until the next START/reset; all reset to 0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, START, then issue ID 0x01 with expected ADD 8'h05+8'h03 (EXP_RES=9'h008, other flags 0); drive RES=9'h008 at issue+3 -> PASS_CNT=1, FAIL_CNT=0; reading addr 0 returns {8'h01,1}.
- Same case with RES driven as 9'h009 -> FAIL_CNT=1; reading addr 0 returns {8'h01,0}; with ALU_CHK_FIRST_FAIL_EN, FIRST_FAIL_ID=0x01 and FIRST_FAIL_OBS[RES_W+5:6]=9'h009.
- Three back-to-back issues (IDs 0x10,0x11,0x12) whose ALU words are correct, correct, and wrong in EGL only -> counts 2/1; memory addrs 0..2 hold IDs in order with pass bits 1,1,0.
- NUM_TC overridden to 4, issue 6 cases -> DONE asserts on the edge of the 4th log, BUSY=0, counters total 4, cases 5-6 are ignored.
- Assert RST two cycles after an issue -> no write occurs, counters stay 0, state IDLE; START then a fresh issue logs at addr 0.
- Drive FAIL_CNT past saturation with NUM_TC=2**PTR_W+2 under PTR_W=2 -> FAIL_CNT holds at 3.
